// File: rtl/pspin_ingress_sched_pkg.sv
// Shared pspin ingress configuration: in-flight counter width and the DMA tag layout
// used by the ingress scheduler, the ingress DMA and HER gen.
package pspin_ingress_sched_pkg;

   localparam int CNT_WIDTH = 4;
   localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

   function automatic int port_width(input int num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

   // DMA tag layout is {port, tag}: the port index sits directly above the requester tag.
   function automatic int dma_tag_width(input int pw, input int tw);
      return pw + tw;
   endfunction

   function automatic int dma_port_lsb(input int tw);
      return tw;
   endfunction

endpackage

// File: rtl/pspin_ingress_sched_rr_arb.sv
// Round-robin selector: first requesting port at or after ptr, wrapping modulo N.
module pspin_ingress_rr_arb #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx,
   output logic          valid
);

   int cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = 0;
      for (int k = 0; k < N; k++) begin
         cand = (int'(ptr) + k) % N;
         if (!valid && req[cand]) begin
            valid       = 1'b1;
            grant[cand] = 1'b1;
            idx         = PW'(cand);
         end
      end
   end

endmodule

// File: rtl/pspin_ingress_sched.sv
// Ingress descriptor scheduler: round-robin shares one ingress DMA among several
// packet-allocator channels with per-port in-flight limits and completion routing.
module pspin_ingress_sched
   import pspin_ingress_sched_pkg::*;
#(
   parameter int  NUM_PORTS       = 4,
   parameter int  ADDR_WIDTH      = 32,
   parameter int  LEN_WIDTH       = 20,
   parameter int  TAG_WIDTH       = 8,
   parameter int  MAX_OUTSTANDING = 4,
   localparam int PORT_WIDTH      = port_width(NUM_PORTS),
   localparam int DMA_TAG_WIDTH   = dma_tag_width(PORT_WIDTH, TAG_WIDTH)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   s_desc_addr,
   input  logic [NUM_PORTS*LEN_WIDTH-1:0]    s_desc_len,
   input  logic [NUM_PORTS*TAG_WIDTH-1:0]    s_desc_tag,
   input  logic [NUM_PORTS-1:0]              s_desc_valid,
   output logic [NUM_PORTS-1:0]              s_desc_ready,
   output logic [ADDR_WIDTH-1:0]             m_desc_addr,
   output logic [LEN_WIDTH-1:0]              m_desc_len,
   output logic [DMA_TAG_WIDTH-1:0]          m_desc_tag,
   output logic                              m_desc_valid,
   input  logic                              m_desc_ready,
   input  logic [ADDR_WIDTH-1:0]             s_cpl_addr,
   input  logic [LEN_WIDTH-1:0]              s_cpl_len,
   input  logic [DMA_TAG_WIDTH-1:0]          s_cpl_tag,
   input  logic                              s_cpl_valid,
   output logic                              s_cpl_ready,
   output logic [ADDR_WIDTH-1:0]             m_cpl_addr,
   output logic [LEN_WIDTH-1:0]              m_cpl_len,
   output logic [TAG_WIDTH-1:0]              m_cpl_tag,
   output logic [NUM_PORTS-1:0]              m_cpl_valid,
   input  logic [NUM_PORTS-1:0]              m_cpl_ready,
   output logic [NUM_PORTS*CNT_WIDTH-1:0]    outstanding
);

   logic [CNT_WIDTH-1:0]  cnt     [NUM_PORTS];
   logic [CNT_WIDTH-1:0]  cnt_eff [NUM_PORTS];
   logic [NUM_PORTS-1:0]  cpl_hs;
   logic [NUM_PORTS-1:0]  req;
   logic [NUM_PORTS-1:0]  grant;
   logic [PORT_WIDTH-1:0] rr_ptr;
   logic [PORT_WIDTH-1:0] gnt_idx;
   logic [PORT_WIDTH-1:0] cpl_port;
   logic                  gnt_valid;
   logic                  out_free;

   assign cpl_port   = s_cpl_tag[dma_port_lsb(TAG_WIDTH) +: PORT_WIDTH];
   assign m_cpl_addr = s_cpl_addr;
   assign m_cpl_len  = s_cpl_len;
   assign m_cpl_tag  = s_cpl_tag[TAG_WIDTH-1:0];

   // A port field with no matching port leaves s_cpl_ready at 1, so the completion is dropped.
   always_comb begin
      m_cpl_valid = '0;
      s_cpl_ready = 1'b1;
      cpl_hs      = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (cpl_port == PORT_WIDTH'(i)) begin
            m_cpl_valid[i] = s_cpl_valid;
            s_cpl_ready    = m_cpl_ready[i];
            cpl_hs[i]      = s_cpl_valid & m_cpl_ready[i];
         end
      end
   end

   assign out_free = !m_desc_valid || m_desc_ready;

   // Completion decrement is applied before the limit test so a full port can be re-granted at once.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         cnt_eff[i] = cnt[i] - CNT_WIDTH'(cpl_hs[i] && (cnt[i] != '0));
         req[i]     = !rst && enable && out_free && s_desc_valid[i] &&
                      (cnt_eff[i] < CNT_WIDTH'(MAX_OUTSTANDING));
      end
   end

   pspin_ingress_rr_arb #(
      .N  (NUM_PORTS),
      .PW (PORT_WIDTH)
   ) u_arb (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (gnt_idx),
      .valid (gnt_valid)
   );

   assign s_desc_ready = grant;

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         outstanding[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_desc_valid <= 1'b0;
         m_desc_addr  <= '0;
         m_desc_len   <= '0;
         m_desc_tag   <= '0;
         rr_ptr       <= '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            cnt[i] <= cnt_eff[i] + CNT_WIDTH'(grant[i]);
         end
         if (gnt_valid) begin
            m_desc_valid <= 1'b1;
            m_desc_addr  <= s_desc_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            m_desc_len   <= s_desc_len[int'(gnt_idx)*LEN_WIDTH +: LEN_WIDTH];
            m_desc_tag   <= {gnt_idx, s_desc_tag[int'(gnt_idx)*TAG_WIDTH +: TAG_WIDTH]};
            rr_ptr       <= (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + PORT_WIDTH'(1);
         end else if (m_desc_ready) begin
            m_desc_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pspin_ingress_sched.sv
// Bench for pspin_ingress_sched: reference model with an expected-descriptor queue,
// a decoupled output monitor, directed scenarios and a randomized soak.
module tb_pspin_ingress_sched;

   localparam int NP   = 4;
   localparam int AW   = 32;
   localparam int LW   = 20;
   localparam int TW   = 8;
   localparam int PW   = 2;
   localparam int DTW  = PW + TW;
   localparam int MAXO = 4;
   localparam int W    = AW + LW + DTW;

   logic             clk;
   logic             rst;
   logic             enable;
   logic [NP*AW-1:0] s_desc_addr;
   logic [NP*LW-1:0] s_desc_len;
   logic [NP*TW-1:0] s_desc_tag;
   logic [NP-1:0]    s_desc_valid;
   logic [NP-1:0]    s_desc_ready;
   logic [AW-1:0]    m_desc_addr;
   logic [LW-1:0]    m_desc_len;
   logic [DTW-1:0]   m_desc_tag;
   logic             m_desc_valid;
   logic             m_desc_ready;
   logic [AW-1:0]    s_cpl_addr;
   logic [LW-1:0]    s_cpl_len;
   logic [DTW-1:0]   s_cpl_tag;
   logic             s_cpl_valid;
   logic             s_cpl_ready;
   logic [AW-1:0]    m_cpl_addr;
   logic [LW-1:0]    m_cpl_len;
   logic [TW-1:0]    m_cpl_tag;
   logic [NP-1:0]    m_cpl_valid;
   logic [NP-1:0]    m_cpl_ready;
   logic [NP*4-1:0]  outstanding;

   // Three-port instance: its 2-bit port field can carry an index with no matching port.
   logic [3*AW-1:0]  d3_s_desc_addr;
   logic [3*LW-1:0]  d3_s_desc_len;
   logic [3*TW-1:0]  d3_s_desc_tag;
   logic [2:0]       d3_s_desc_valid;
   logic [2:0]       d3_s_desc_ready;
   logic [AW-1:0]    d3_m_desc_addr;
   logic [LW-1:0]    d3_m_desc_len;
   logic [DTW-1:0]   d3_m_desc_tag;
   logic             d3_m_desc_valid;
   logic [DTW-1:0]   d3_cpl_tag;
   logic             d3_cpl_valid;
   logic             d3_s_cpl_ready;
   logic [AW-1:0]    d3_m_cpl_addr;
   logic [LW-1:0]    d3_m_cpl_len;
   logic [TW-1:0]    d3_m_cpl_tag;
   logic [2:0]       d3_m_cpl_valid;
   logic [2:0]       d3_m_cpl_ready;
   logic [11:0]      d3_outstanding;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   int mcnt [NP];
   int mptr;
   bit mout;

   pspin_ingress_sched dut (
      .clk(clk), .rst(rst), .enable(enable),
      .s_desc_addr(s_desc_addr), .s_desc_len(s_desc_len), .s_desc_tag(s_desc_tag),
      .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
      .m_desc_addr(m_desc_addr), .m_desc_len(m_desc_len), .m_desc_tag(m_desc_tag),
      .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
      .s_cpl_addr(s_cpl_addr), .s_cpl_len(s_cpl_len), .s_cpl_tag(s_cpl_tag),
      .s_cpl_valid(s_cpl_valid), .s_cpl_ready(s_cpl_ready),
      .m_cpl_addr(m_cpl_addr), .m_cpl_len(m_cpl_len), .m_cpl_tag(m_cpl_tag),
      .m_cpl_valid(m_cpl_valid), .m_cpl_ready(m_cpl_ready),
      .outstanding(outstanding)
   );

   pspin_ingress_sched #(.NUM_PORTS(3)) dut3 (
      .clk(clk), .rst(rst), .enable(1'b0),
      .s_desc_addr(d3_s_desc_addr), .s_desc_len(d3_s_desc_len), .s_desc_tag(d3_s_desc_tag),
      .s_desc_valid(d3_s_desc_valid), .s_desc_ready(d3_s_desc_ready),
      .m_desc_addr(d3_m_desc_addr), .m_desc_len(d3_m_desc_len), .m_desc_tag(d3_m_desc_tag),
      .m_desc_valid(d3_m_desc_valid), .m_desc_ready(1'b1),
      .s_cpl_addr(s_cpl_addr), .s_cpl_len(s_cpl_len), .s_cpl_tag(d3_cpl_tag),
      .s_cpl_valid(d3_cpl_valid), .s_cpl_ready(d3_s_cpl_ready),
      .m_cpl_addr(d3_m_cpl_addr), .m_cpl_len(d3_m_cpl_len), .m_cpl_tag(d3_m_cpl_tag),
      .m_cpl_valid(d3_m_cpl_valid), .m_cpl_ready(d3_m_cpl_ready),
      .outstanding(d3_outstanding)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      s_desc_valid   = '0;
      s_cpl_valid    = 1'b0;
      m_cpl_ready    = '0;
      m_desc_ready   = 1'b1;
      d3_cpl_valid   = 1'b0;
      d3_m_cpl_ready = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_desc(input int p, input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input logic [TW-1:0] t);
      s_desc_addr[p*AW +: AW] = a;
      s_desc_len[p*LW +: LW]  = l;
      s_desc_tag[p*TW +: TW]  = t;
   endtask

   // reference model: spec-level counts, pointer and output-slot occupancy
   always @(negedge clk) begin
      int p;
      int g;
      int cand;
      int eff [NP];
      bit fire;
      bit free;
      logic [15:0] packed_cnt;
      if (rst) begin
         chk("rst_sready", s_desc_ready, 0);
         for (int i = 0; i < NP; i++) mcnt[i] = 0;
         mptr = 0;
         mout = 1'b0;
         exp_q.delete();
      end else begin
         p = int'(s_cpl_tag[DTW-1:TW]);
         fire = s_cpl_valid && m_cpl_ready[p];
         chk("cpl_route", m_cpl_valid, s_cpl_valid ? (1 << p) : 0);
         chk("cpl_ready", s_cpl_ready, m_cpl_ready[p]);
         if (s_cpl_valid)
            chk("cpl_data", {m_cpl_addr, m_cpl_len, m_cpl_tag},
                {s_cpl_addr, s_cpl_len, s_cpl_tag[TW-1:0]});
         for (int i = 0; i < NP; i++) packed_cnt[i*4 +: 4] = 4'(mcnt[i]);
         chk("outstanding", outstanding, packed_cnt);
         chk("desc_valid", m_desc_valid, mout);
         for (int i = 0; i < NP; i++)
            eff[i] = mcnt[i] - ((fire && p == i && mcnt[i] > 0) ? 1 : 0);
         free = !mout || m_desc_ready;
         g = -1;
         if (enable && free) begin
            for (int k = 0; k < NP; k++) begin
               cand = (mptr + k) % NP;
               if (g < 0 && s_desc_valid[cand] && eff[cand] < MAXO) g = cand;
            end
         end
         chk("desc_grant", s_desc_ready, (g >= 0) ? (1 << g) : 0);
         for (int i = 0; i < NP; i++) mcnt[i] = eff[i] + ((i == g) ? 1 : 0);
         if (g >= 0) begin
            mout = 1'b1;
            mptr = (g + 1) % NP;
            exp_q.push_back({s_desc_addr[g*AW +: AW], s_desc_len[g*LW +: LW], 2'(g),
                             s_desc_tag[g*TW +: TW]});
         end else if (m_desc_ready) begin
            mout = 1'b0;
         end
      end
   end

   // output monitor
   always @(negedge clk) begin
      logic [W-1:0] exp;
      if (!rst && m_desc_valid && m_desc_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL desc_out: got descriptor 0x%0h with no expected entry at %0t",
                     {m_desc_addr, m_desc_len, m_desc_tag}, $time);
         end else begin
            exp = exp_q.pop_front();
            chk("desc_out", {m_desc_addr, m_desc_len, m_desc_tag}, exp);
         end
      end
   end

   initial begin
      logic [DTW-1:0] tg;
      rst = 1'b1;
      enable = 1'b1;
      s_desc_addr = '0;
      s_desc_len = '0;
      s_desc_tag = '0;
      s_cpl_addr = '0;
      s_cpl_len = '0;
      s_cpl_tag = '0;
      d3_cpl_tag = '0;
      d3_s_desc_addr = '0;
      d3_s_desc_len = '0;
      d3_s_desc_tag = '0;
      d3_s_desc_valid = '0;
      idle();
      do_reset();
      @(negedge clk);
      chk("reset_state", {m_desc_valid, m_desc_addr, m_desc_len, m_desc_tag, outstanding}, 0);
      tick();

      // all ports valid, sink always ready: 0,1,2,3,0,... one per cycle
      do_reset();
      for (int p = 0; p < NP; p++) set_desc(p, 32'h2000_0000 + 32'(p * 256), 20'(64 + p), 8'(p + 16));
      s_desc_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("rr_order", s_desc_ready, 1 << (k % 4));
         chk("rr_latency", m_desc_valid, (k != 0) ? 1 : 0);
         tick();
      end

      // port 2 reaches its limit, then one completion re-opens it in the same cycle
      do_reset();
      s_desc_valid = 4'b0100;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("p2_limit", s_desc_ready, (k < 4) ? 4'b0100 : 4'b0000);
         tick();
      end
      @(negedge clk);
      chk("p2_count", outstanding[11:8], 4);
      tick();
      s_cpl_tag = {2'd2, 8'h33};
      s_cpl_valid = 1'b1;
      m_cpl_ready = 4'b0100;
      @(negedge clk);
      chk("p2_regrant", s_desc_ready, 4'b0100);
      chk("p2_cpl_ready", s_cpl_ready, 1);
      tick();
      s_cpl_valid = 1'b0;
      m_cpl_ready = '0;
      s_desc_valid = '0;
      @(negedge clk);
      chk("p2_count_after", outstanding[11:8], 4);
      tick();

      // sink stalls for 5 cycles with a registered descriptor
      do_reset();
      set_desc(1, 32'h1000_0040, 20'd128, 8'h77);
      set_desc(0, 32'h3000_0000, 20'd256, 8'h01);
      m_desc_ready = 1'b0;
      s_desc_valid = 4'b0010;
      @(negedge clk);
      chk("stall_grant", s_desc_ready, 4'b0010);
      tick();
      s_desc_valid = 4'b0011;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_hold", {m_desc_valid, m_desc_addr, m_desc_tag}, {1'b1, 32'h1000_0040, 2'd1, 8'h77});
         chk("stall_no_grant", s_desc_ready, 0);
         tick();
      end
      m_desc_ready = 1'b1;
      @(negedge clk);
      chk("stall_xfer", {m_desc_valid, m_desc_addr}, {1'b1, 32'h1000_0040});
      chk("stall_next_grant", s_desc_ready, 4'b0001);
      tick();
      s_desc_valid = '0;
      @(negedge clk);
      chk("stall_next_desc", m_desc_addr, 32'h3000_0000);
      tick();

      // completion to port 1 back-pressured for 3 cycles
      s_cpl_tag = {2'd1, 8'h5A};
      s_cpl_addr = 32'hABCD_0000;
      s_cpl_len = 20'd99;
      s_cpl_valid = 1'b1;
      m_cpl_ready = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("cpl_bp_valid", m_cpl_valid, 4'b0010);
         chk("cpl_bp_ready", s_cpl_ready, 0);
         chk("cpl_bp_tag", m_cpl_tag, 8'h5A);
         chk("cpl_bp_count", outstanding[7:4], 1);
         tick();
      end
      m_cpl_ready = 4'b0010;
      @(negedge clk);
      chk("cpl_hs_ready", s_cpl_ready, 1);
      tick();
      s_cpl_valid = 1'b0;
      m_cpl_ready = '0;
      @(negedge clk);
      chk("cpl_dec", outstanding[7:4], 0);
      tick();

      // simultaneous grant and completion on port 0
      s_desc_valid = 4'b0001;
      s_cpl_tag = {2'd0, 8'h11};
      s_cpl_valid = 1'b1;
      m_cpl_ready = 4'b0001;
      @(negedge clk);
      chk("same_cycle_grant", s_desc_ready, 4'b0001);
      chk("same_cycle_cpl", s_cpl_ready, 1);
      tick();
      idle();
      @(negedge clk);
      chk("same_cycle_count", outstanding[3:0], 1);
      tick();

      // unmatched port field on the three-port instance is accepted and dropped
      d3_cpl_tag = {2'd3, 8'h05};
      d3_cpl_valid = 1'b1;
      d3_m_cpl_ready = 3'b111;
      @(negedge clk);
      chk("drop_ready", d3_s_cpl_ready, 1);
      chk("drop_no_valid", d3_m_cpl_valid, 0);
      tick();
      d3_cpl_tag = {2'd1, 8'h44};
      d3_m_cpl_ready = 3'b000;
      @(negedge clk);
      chk("drop_count", d3_outstanding, 0);
      chk("d3_route", {d3_m_cpl_valid, d3_s_cpl_ready}, {3'b010, 1'b0});
      chk("d3_cpl_data", {d3_m_cpl_addr, d3_m_cpl_len, d3_m_cpl_tag}, {s_cpl_addr, s_cpl_len, 8'h44});
      chk("d3_idle", {d3_m_desc_valid, d3_s_desc_ready, d3_m_desc_tag}, 0);
      chk("d3_idle_data", {d3_m_desc_addr, d3_m_desc_len}, 0);
      tick();
      idle();

      // reset mid-operation with counts {3,1,0,2} and a held descriptor
      do_reset();
      m_desc_ready = 1'b1;
      begin
         int seq [6] = '{0, 0, 0, 1, 3, 3};
         for (int k = 0; k < 6; k++) begin
            s_desc_valid = 4'(1 << seq[k]);
            @(negedge clk);
            chk("pre_rst_grant", s_desc_ready, 1 << seq[k]);
            tick();
         end
      end
      s_desc_valid = '0;
      m_desc_ready = 1'b0;
      @(negedge clk);
      chk("pre_rst_counts", outstanding, 16'h2013);
      chk("pre_rst_valid", m_desc_valid, 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      s_desc_valid = 4'hF;
      m_desc_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", m_desc_valid, 0);
      chk("post_rst_counts", outstanding, 0);
      chk("post_rst_first", s_desc_ready, 4'b0001);
      tick();

      // randomized soak
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         for (int p = 0; p < NP; p++) set_desc(p, 32'($urandom), 20'($urandom), 8'($urandom));
         s_desc_valid = 4'($urandom);
         m_desc_ready = ($urandom_range(0, 3) != 0);
         enable = ($urandom_range(0, 9) != 0);
         tg = {2'($urandom_range(0, 3)), 8'($urandom)};
         s_cpl_tag = tg;
         s_cpl_addr = 32'($urandom);
         s_cpl_len = 20'($urandom);
         s_cpl_valid = $urandom_range(0, 1);
         m_cpl_ready = 4'($urandom);
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;
      enable = 1'b1;
      idle();
      repeat (3) tick();
      @(negedge clk);
      chk("drain_queue", exp_q.size(), 0);
      chk("drain_valid", m_desc_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
